alu_pwr_seq: RTL and testbench



---
 rtl/alu_pwr_seq.sv | 255 +++++++++++++++++++++++++
 tb/tb_alu_pwr_seq.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pwr_seq.sv
// ---------------------------------------------------------------------------
// alu_pwr_seq
//
// Command and power sequencer sitting in front of a power-gated ALU domain.
// Commands (operands + opcode) arrive over a valid/ready interface. When the
// ALU domain is off, the first offered command powers it up: alu_pwr_en
// rises first, then isolation is released once the domain has had
// PWR_UP_CYCLES cycles to settle. Each accepted command produces exactly one
// alu_start pulse. The sequencer then waits for alu_busy to drop, or gives up
// after BUSY_TIMEOUT cycles, and returns the result over a valid/ready
// response interface. After IDLE_TIMEOUT idle cycles the domain is powered
// down again: isolation goes up first, then alu_pwr_en drops.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (cmd_ready is combinational)
//   cmd_a, cmd_b, cmd_op       command payload
//   rsp_valid/rsp_ready        response handshake
//   rsp_data, rsp_err          captured result, busy-timeout flag (data=0)
//   alu_pwr_en, iso_en         ALU domain power enable and output isolation
//   alu_start                  one-cycle start pulse to the ALU
//   alu_a, alu_b, alu_opcode   operands held stable for the ALU
//   alu_result, alu_busy       ALU result and busy status
//
// All outputs except cmd_ready come straight from flops.
// ---------------------------------------------------------------------------
module alu_pwr_seq #(
    parameter int W             = 16,
    parameter int PWR_UP_CYCLES = 4,
    parameter int IDLE_TIMEOUT  = 16,
    parameter int BUSY_TIMEOUT  = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    input  logic [3:0]   cmd_op,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_err,
    output logic         alu_pwr_en,
    output logic         iso_en,
    output logic         alu_start,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_opcode,
    input  logic [W-1:0] alu_result,
    input  logic         alu_busy
);

    typedef enum logic [2:0] {
        S_OFF,
        S_PWR_UP,
        S_ON,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_ISO_ON,
        S_PWR_DN
    } state_t;

    // Each counter only has to reach its limit minus one.
    localparam int PW = $clog2(PWR_UP_CYCLES + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam int BW = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [PW-1:0] PWR_LAST  = PW'(PWR_UP_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
    localparam logic [BW-1:0] BUSY_LAST = BW'(BUSY_TIMEOUT - 1);

    state_t        state_q,     state_d;
    logic          pwr_en_q,    pwr_en_d;
    logic          iso_q,       iso_d;
    logic          start_q,     start_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q,   rsp_err_d;
    logic [W-1:0]  rsp_data_q,  rsp_data_d;
    logic [W-1:0]  a_q,         a_d;
    logic [W-1:0]  b_q,         b_d;
    logic [3:0]    op_q,        op_d;
    logic [PW-1:0] pwr_cnt_q,   pwr_cnt_d;
    logic [IW-1:0] idle_cnt_q,  idle_cnt_d;
    logic [BW-1:0] wait_cnt_q,  wait_cnt_d;

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pwr_en_d    = pwr_en_q;
        iso_d       = iso_q;
        start_d     = 1'b0;          // start is a pulse unless re-armed below
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        pwr_cnt_d   = pwr_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            S_OFF: begin
                pwr_en_d = 1'b0;
                iso_d    = 1'b1;
                // The command is only noted here; it is accepted later in ON.
                if (cmd_valid) begin
                    state_d   = S_PWR_UP;
                    pwr_en_d  = 1'b1;
                    pwr_cnt_d = '0;
                end
            end

            S_PWR_UP: begin
                // Isolation stays up until the domain has been powered for
                // the full settle time; the release lands in the first ON cycle.
                if (pwr_cnt_q == PWR_LAST) begin
                    state_d    = S_ON;
                    iso_d      = 1'b0;
                    idle_cnt_d = '0;
                    pwr_cnt_d  = '0;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + PW'(1);
                end
            end

            S_ON: begin
                if (cmd_valid) begin
                    // cmd_ready is high in ON, so valid alone is a handshake.
                    state_d    = S_ISSUE;
                    a_d        = cmd_a;
                    b_d        = cmd_b;
                    op_d       = cmd_op;
                    start_d    = 1'b1;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d    = S_ISO_ON;
                    iso_d      = 1'b1;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + IW'(1);
                end
            end

            S_ISSUE: begin
                // alu_start is high during this cycle only.
                state_d    = S_WAIT;
                wait_cnt_d = '0;
            end

            S_WAIT: begin
                // The ALU sees alu_start at the ISSUE edge and can raise
                // busy for the following cycle, so busy is trusted from the
                // end of the first WAIT cycle onwards. A completion seen in
                // the last permitted cycle still wins over the timeout.
                if (!alu_busy) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = alu_result;
                    wait_cnt_d  = '0;
                end else if (wait_cnt_q == BUSY_LAST) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                    wait_cnt_d  = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + BW'(1);
                end
            end

            S_RESP: begin
                // Response fields hold until the consumer takes them.
                if (rsp_ready) begin
                    state_d     = S_ON;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    idle_cnt_d  = '0;
                end
            end

            S_ISO_ON: begin
                // Isolation has been up for one cycle; now remove power.
                state_d  = S_PWR_DN;
                pwr_en_d = 1'b0;
            end

            S_PWR_DN: begin
                // A command offered now is picked up again from OFF.
                state_d = S_OFF;
            end

            default: begin
                state_d  = S_OFF;
                pwr_en_d = 1'b0;
                iso_d    = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_OFF;
            pwr_en_q    <= 1'b0;
            iso_q       <= 1'b1;
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            pwr_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pwr_en_q    <= pwr_en_d;
            iso_q       <= iso_d;
            start_q     <= start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            pwr_cnt_q   <= pwr_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cmd_ready  = (state_q == S_ON);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign alu_pwr_en = pwr_en_q;
    assign iso_en     = iso_q;
    assign alu_start  = start_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_opcode = op_q;

endmodule

// File: tb/tb_alu_pwr_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_pwr_seq
//
// Directed and randomized bench for alu_pwr_seq. A small behavioural ALU
// answers alu_start with a configurable number of busy cycles. Expected
// responses and latencies come from a reference function that works directly
// from the command and the chosen busy length.
// ---------------------------------------------------------------------------
module tb_alu_pwr_seq;

    localparam int W    = 16;
    localparam int PUC  = 4;
    localparam int IDLE = 16;
    localparam int BT   = 64;
    localparam int FOREVER_BUSY = 1000000;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [3:0]   cmd_op;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_err;
    logic         alu_pwr_en;
    logic         iso_en;
    logic         alu_start;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_opcode;
    logic [W-1:0] alu_result;
    logic         alu_busy;

    int checks_total  = 0;
    int checks_passed = 0;
    int start_cnt     = 0;
    int iso_high_cnt  = 0;
    int busy_len      = 0;
    int busy_rem      = 0;
    bit mon_en        = 1'b0;

    alu_pwr_seq #(
        .W            (W),
        .PWR_UP_CYCLES(PUC),
        .IDLE_TIMEOUT (IDLE),
        .BUSY_TIMEOUT (BT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .alu_pwr_en(alu_pwr_en),
        .iso_en    (iso_en),
        .alu_start (alu_start),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_opcode(alu_opcode),
        .alu_result(alu_result),
        .alu_busy  (alu_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Behavioural ALU: on a start pulse latch the result, then report busy
    // for busy_len consecutive sampling edges.
    always @(negedge clk) begin
        if (alu_start === 1'b1) begin
            busy_rem   = busy_len;
            alu_busy   = 1'b0;
            alu_result = alu_fn(alu_a, alu_b, alu_opcode);
        end else begin
            alu_busy = (busy_rem > 0);
            if (busy_rem > 0) busy_rem--;
        end
    end

    // Power invariants, start-pulse and isolation bookkeeping.
    always @(negedge clk) begin
        if (mon_en) begin
            if (alu_start === 1'b1) start_cnt++;
            if (iso_en === 1'b1) iso_high_cnt++;
            chk("inv_iso_when_off", {31'd0, (alu_pwr_en === 1'b0) && (iso_en !== 1'b1)}, 32'd0);
            if (alu_start === 1'b1)
                chk("inv_start_powered", {30'd0, alu_pwr_en, iso_en}, 32'd2);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One command through the sequencer, with the response consumer
    // stalling for rdy_wait cycles.
    task automatic do_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                          input int blen, input int rdy_wait);
        int n;
        int k;
        int s0;
        int exp_lat;
        logic [W-1:0] exp_d;
        logic exp_e;
        exp_e   = (blen >= BT);
        exp_d   = exp_e ? '0 : alu_fn(a, b, op);
        exp_lat = exp_e ? BT + 2 : blen + 3;
        busy_len  = blen;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_valid = 1'b1;
        rsp_ready = 1'b0;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            chk("hs_timeout", {31'd0, cmd_ready}, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        s0 = start_cnt;
        step();
        cmd_valid = 1'b0;
        chk("issue_start", {31'd0, alu_start}, 32'd1);
        chk("issue_a", {16'd0, alu_a}, {16'd0, a});
        chk("issue_b", {16'd0, alu_b}, {16'd0, b});
        chk("issue_op", {28'd0, alu_opcode}, {28'd0, op});
        k = 1;
        while (rsp_valid !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        chk("rsp_latency", k, exp_lat);
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_data", {16'd0, rsp_data}, {16'd0, exp_d});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_e});
        for (int i = 0; i < rdy_wait; i++) begin
            step();
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_data", {16'd0, rsp_data}, {16'd0, exp_d});
            chk("hold_err", {31'd0, rsp_err}, {31'd0, exp_e});
            chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("post_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("one_start", start_cnt - s0, 32'd1);
        $display("txn a=%0h b=%0h op=%0d busy=%0d stall=%0d -> data=%0h err=%0b lat=%0d",
                 a, b, op, blen, rdy_wait, exp_d, exp_e, k);
    endtask

    initial begin
        int iso0;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [3:0]   rop;
        int rl;
        int rw;
        int gap;

        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_a      = '0;
        cmd_b      = '0;
        cmd_op     = '0;
        rsp_ready  = 1'b0;
        alu_busy   = 1'b0;
        alu_result = '0;

        // Reset values
        step(); step(); step();
        mon_en = 1'b1;
        chk("rst_pwr_en", {31'd0, alu_pwr_en}, 32'd0);
        chk("rst_iso", {31'd0, iso_en}, 32'd1);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        chk("rst_start", {31'd0, alu_start}, 32'd0);
        chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
        chk("rst_alu_op", {28'd0, alu_opcode}, 32'd0);
        rst = 1'b0;
        step();

        // Cold command: 5 + 3, ALU never busy
        busy_len  = 0;
        rsp_ready = 1'b1;
        cmd_a = 16'd5; cmd_b = 16'd3; cmd_op = 4'd0; cmd_valid = 1'b1;   // cycle 0
        step();                                                          // cycle 1
        chk("cold_c1_pwr_en", {31'd0, alu_pwr_en}, 32'd1);
        chk("cold_c1_iso", {31'd0, iso_en}, 32'd1);
        step(); step(); step();                                          // cycle 4
        chk("cold_c4_iso", {31'd0, iso_en}, 32'd1);
        chk("cold_c4_ready", {31'd0, cmd_ready}, 32'd0);
        step();                                                          // cycle 5
        chk("cold_c5_iso", {31'd0, iso_en}, 32'd0);
        chk("cold_c5_ready", {31'd0, cmd_ready}, 32'd1);
        step();                                                          // cycle 6
        cmd_valid = 1'b0;
        chk("cold_c6_start", {31'd0, alu_start}, 32'd1);
        chk("cold_c6_ready", {31'd0, cmd_ready}, 32'd0);
        step();                                                          // cycle 7
        chk("cold_c7_start", {31'd0, alu_start}, 32'd0);
        chk("cold_c7_valid", {31'd0, rsp_valid}, 32'd0);
        step();                                                          // cycle 8
        chk("cold_c8_valid", {31'd0, rsp_valid}, 32'd1);
        chk("cold_c8_data", {16'd0, rsp_data}, 32'd8);
        chk("cold_c8_err", {31'd0, rsp_err}, 32'd0);
        step();                                                          // cycle 9
        chk("cold_c9_valid", {31'd0, rsp_valid}, 32'd0);
        chk("cold_c9_ready", {31'd0, cmd_ready}, 32'd1);
        $display("txn cold a=5 b=3 op=0 -> data=8");

        // Back-to-back, ALU busy for 3 cycles each, no power-down between
        iso0 = iso_high_cnt;
        do_cmd(16'h1234, 16'h0101, 4'd0, 3, 0);
        do_cmd(16'h00f0, 16'h0010, 4'd1, 3, 0);
        do_cmd(16'hff00, 16'h0ff0, 4'd4, 3, 0);
        chk("b2b_iso_stayed_low", iso_high_cnt - iso0, 32'd0);
        chk("b2b_pwr_en", {31'd0, alu_pwr_en}, 32'd1);

        // Idle power-down; a command offered in ISO_ON is not accepted
        for (int i = 1; i <= IDLE - 1; i++) begin
            step();
            chk("idle_iso_low", {31'd0, iso_en}, 32'd0);
        end
        step();
        chk("idle_iso_on", {31'd0, iso_en}, 32'd1);
        chk("idle_iso_pwr", {31'd0, alu_pwr_en}, 32'd1);
        chk("idle_iso_ready", {31'd0, cmd_ready}, 32'd0);
        cmd_a = 16'h0007; cmd_b = 16'h0009; cmd_op = 4'd2; cmd_valid = 1'b1;
        step();
        chk("pwr_dn_pwr_en", {31'd0, alu_pwr_en}, 32'd0);
        chk("pwr_dn_iso", {31'd0, iso_en}, 32'd1);
        chk("pwr_dn_ready", {31'd0, cmd_ready}, 32'd0);
        step();
        chk("off_pwr_en", {31'd0, alu_pwr_en}, 32'd0);
        chk("off_start", {31'd0, alu_start}, 32'd0);
        step();
        chk("repower_pwr_en", {31'd0, alu_pwr_en}, 32'd1);
        chk("repower_iso", {31'd0, iso_en}, 32'd1);
        do_cmd(16'h0007, 16'h0009, 4'd2, 1, 0);

        // Backpressure for 10 cycles
        do_cmd(16'hbeef, 16'h0001, 4'd0, 2, 10);

        // Busy timeout
        do_cmd(16'h4444, 16'h2222, 4'd3, FOREVER_BUSY, 1);
        do_cmd(16'h0003, 16'h0004, 4'd0, BT - 1, 0);

        // Randomized commands with random stalls and idle gaps
        for (int t = 0; t < 20; t++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rop = 4'($urandom_range(0, 7));
            rl  = ($urandom_range(0, 9) == 0) ? BT + 5 : int'($urandom_range(0, 6));
            rw  = int'($urandom_range(0, 3));
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(IDLE, IDLE + 8))
                                              : int'($urandom_range(0, 4));
            do_cmd(ra, rb, rop, rl, rw);
            for (int g = 0; g < gap; g++) step();
        end

        // Reset during WAIT discards the command
        busy_len  = FOREVER_BUSY;
        cmd_a = 16'h0aaa; cmd_b = 16'h0555; cmd_op = 4'd0; cmd_valid = 1'b1;
        for (int n = 0; n < 100 && cmd_ready !== 1'b1; n++) step();
        chk("mid_ready", {31'd0, cmd_ready}, 32'd1);
        step();
        cmd_valid = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        chk("midrst_pwr_en", {31'd0, alu_pwr_en}, 32'd0);
        chk("midrst_iso", {31'd0, iso_en}, 32'd1);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("midrst_alu_a", {16'd0, alu_a}, 32'd0);
        rst = 1'b0;
        busy_len = 0;
        for (int i = 0; i < 5; i++) step();
        chk("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_still_off", {31'd0, alu_pwr_en}, 32'd0);
        do_cmd(16'h0100, 16'h0023, 4'd1, 0, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    // Safety net in case the sequence itself stalls.
    initial begin
        #2000000;
        $display("FAIL global_timeout: observed=stalled expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
